// File: rtl/regfile_scoreboarded.sv
// rtl/regfile_scoreboarded.sv - parametrised register file with per-register pending-write scoreboard
module regfile_scoreboarded #(
  parameter  int WORD_SIZE = 32,
  parameter  int NUM_REGS  = 32,
  parameter  int NUM_READ  = 2,
  parameter  int NUM_WRITE = 2,
  parameter  int PEND_W    = 2,
  parameter  bit BYPASS    = 1'b1,
  localparam int TAG_W     = $clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ*TAG_W-1:0]      rd_tag,
  output logic [NUM_READ*WORD_SIZE-1:0]  rd_value,
  output logic [NUM_READ-1:0]            rd_pending,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*TAG_W-1:0]     wr_tag,
  input  logic [NUM_WRITE*WORD_SIZE-1:0] wr_value,
  input  logic                           issue_valid,
  input  logic [TAG_W-1:0]               issue_tag,
  output logic                           issue_ready,
  input  logic                           flush,
  output logic                           underflow_err
);

  // Sum width holds count + one issue and compares against up to NUM_WRITE decrements.
  localparam int DEC_W = $clog2(NUM_WRITE + 1);
  localparam int SUM_W = PEND_W + DEC_W + 1;
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0]    r_cnt  [NUM_REGS];
  logic                 r_underflow;

  logic                 w_issue_ready;
  logic [SUM_W-1:0]     w_dec      [NUM_REGS];
  logic [SUM_W-1:0]     w_sum      [NUM_REGS];
  logic [PEND_W-1:0]    w_cnt_next [NUM_REGS];
  logic [WORD_SIZE-1:0] w_reg_next [NUM_REGS];
  logic                 w_uf_hit;

  // Register 0 never holds a producer, so issuing to it is always accepted.
  assign w_issue_ready = (issue_tag == '0) || (r_cnt[issue_tag] != PMAX);
  assign issue_ready   = w_issue_ready;
  assign underflow_err = r_underflow;

  // Decode writeback ports: count hits per register and pick the highest-index port's data.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_dec[r]      = '0;
      w_reg_next[r] = r_regs[r];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_en[j] && (wr_tag[j*TAG_W +: TAG_W] == TAG_W'(r))) begin
          w_dec[r]      = w_dec[r] + SUM_W'(1);
          w_reg_next[r] = wr_value[j*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  // Next pending count: add an accepted issue, subtract writebacks, clamp at zero; flush wins.
  always_comb begin
    w_uf_hit      = 1'b0;
    w_sum[0]      = '0;
    w_cnt_next[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_sum[r] = SUM_W'(r_cnt[r])
               + SUM_W'(issue_valid && w_issue_ready && (issue_tag == TAG_W'(r)));
      if (flush) begin
        w_cnt_next[r] = '0;
      end else if (w_sum[r] < w_dec[r]) begin
        w_cnt_next[r] = '0;
        w_uf_hit      = 1'b1;
      end else begin
        w_cnt_next[r] = PEND_W'(w_sum[r] - w_dec[r]);
      end
    end
  end

  // Read ports: array lookup, optionally overridden by a same-cycle write; pending never bypassed.
  always_comb begin
    rd_value   = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_value[i*WORD_SIZE +: WORD_SIZE] = r_regs[rd_tag[i*TAG_W +: TAG_W]];
      rd_pending[i] = (r_cnt[rd_tag[i*TAG_W +: TAG_W]] != '0);
      if (BYPASS) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (rd_tag[i*TAG_W +: TAG_W] != '0) &&
              (wr_tag[j*TAG_W +: TAG_W] == rd_tag[i*TAG_W +: TAG_W])) begin
            rd_value[i*WORD_SIZE +: WORD_SIZE] = wr_value[j*WORD_SIZE +: WORD_SIZE];
          end
        end
      end
    end
  end

  // State update: data, counters and the sticky underflow flag; reset clears everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= w_reg_next[r];
        r_cnt[r]  <= w_cnt_next[r];
      end
      r_underflow <= r_underflow | w_uf_hit;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboarded.sv
// tb/tb_regfile_scoreboarded.sv - randomized and directed bench for regfile_scoreboarded
module tb_regfile_scoreboarded;
  localparam int W = 32, NR = 32, TW = 5, NRD = 2, NWR = 2, PMAX = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic [NRD*TW-1:0] rd_tag;
  logic [NRD*W-1:0]  rd_value_b, rd_value_n;
  logic [NRD-1:0]    rd_pending_b, rd_pending_n;
  logic [NWR-1:0]    wr_en;
  logic [NWR*TW-1:0] wr_tag;
  logic [NWR*W-1:0]  wr_value;
  logic              issue_valid;
  logic [TW-1:0]     issue_tag;
  logic              issue_ready_b, issue_ready_n;
  logic              flush;
  logic              uf_b, uf_n;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] m_mem [NR];
  int           m_cnt [NR];
  bit           m_uf;

  always #5 clock = ~clock;

  regfile_scoreboarded #(.BYPASS(1'b1)) u_byp (
    .clock(clock), .reset_n(reset_n), .rd_tag(rd_tag), .rd_value(rd_value_b),
    .rd_pending(rd_pending_b), .wr_en(wr_en), .wr_tag(wr_tag), .wr_value(wr_value),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready_b),
    .flush(flush), .underflow_err(uf_b));

  regfile_scoreboarded #(.BYPASS(1'b0)) u_nobyp (
    .clock(clock), .reset_n(reset_n), .rd_tag(rd_tag), .rd_value(rd_value_n),
    .rd_pending(rd_pending_n), .wr_en(wr_en), .wr_tag(wr_tag), .wr_value(wr_value),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready_n),
    .flush(flush), .underflow_err(uf_n));

  task automatic idle();
    wr_en = '0; wr_tag = '0; wr_value = '0;
    issue_valid = 1'b0; issue_tag = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int tag);
    rd_tag[p*TW +: TW] = TW'(tag);
  endtask

  task automatic set_wr(input int p, input int tag, input logic [W-1:0] val);
    wr_en[p] = 1'b1;
    wr_tag[p*TW +: TW] = TW'(tag);
    wr_value[p*W +: W] = val;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_uf = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_read(input int tag, input bit byp);
    logic [W-1:0] v;
    if (tag == 0) return '0;
    v = m_mem[tag];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_tag[j*TW +: TW]) == tag) v = wr_value[j*W +: W];
    return v;
  endfunction

  function automatic bit exp_ready();
    return (issue_tag == '0) || (m_cnt[issue_tag] < PMAX);
  endfunction

  // Scoreboard rule: count + accepted issue - writebacks, floored at zero; flush zeroes all.
  task automatic model_edge();
    bit ready;
    int inc, dec;
    ready = exp_ready();
    for (int r = 1; r < NR; r++) begin
      inc = (issue_valid && ready && int'(issue_tag) == r) ? 1 : 0;
      dec = 0;
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_tag[j*TW +: TW]) == r) dec++;
      if (flush) m_cnt[r] = 0;
      else if (m_cnt[r] + inc < dec) begin m_cnt[r] = 0; m_uf = 1'b1; end
      else m_cnt[r] = m_cnt[r] + inc - dec;
    end
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_tag[j*TW +: TW] != '0) m_mem[wr_tag[j*TW +: TW]] = wr_value[j*W +: W];
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle(); rd_tag = '0;
    model_reset();
    set_rd(0, 0); set_rd(1, 5);
    #12;
    n_cmp++; if (rd_value_b !== 64'h0) begin n_fail++; $display("FAIL reset_read_0_5 got %h want 0", rd_value_b); end
    n_cmp++; if (rd_pending_b !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b want 00", rd_pending_b); end
    set_rd(0, 31);
    #1;
    n_cmp++; if (rd_value_n[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_read_31 got %h want 0", rd_value_n[31:0]); end
    n_cmp++; if (uf_b !== 1'b0 || uf_n !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b%b want 00", uf_b, uf_n); end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_bypass();
    issue_valid = 1'b1; issue_tag = 5'd3;
    tick(); idle();
    set_rd(0, 3); set_wr(0, 3, 32'hDEADBEEF);
    #1;
    n_cmp++; if (rd_value_b[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got %h want deadbeef", rd_value_b[31:0]); end
    n_cmp++; if (rd_value_n[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle got %h want 0", rd_value_n[31:0]); end
    n_cmp++; if (rd_pending_b[0] !== 1'b1) begin n_fail++; $display("FAIL pending_not_bypassed got %b want 1", rd_pending_b[0]); end
    tick(); idle();
    #1;
    n_cmp++; if (rd_value_n[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle got %h want deadbeef", rd_value_n[31:0]); end
    n_cmp++; if (rd_pending_b[0] !== 1'b0) begin n_fail++; $display("FAIL pending_after_wb got %b want 0", rd_pending_b[0]); end
    set_rd(1, 0); set_wr(0, 0, 32'h1234);
    #1;
    n_cmp++; if (rd_value_b[63:32] !== 32'h0) begin n_fail++; $display("FAIL reg0_bypass got %h want 0", rd_value_b[63:32]); end
    tick(); idle();
    #1;
    n_cmp++; if (rd_value_n[63:32] !== 32'h0) begin n_fail++; $display("FAIL reg0_write_ignored got %h want 0", rd_value_n[63:32]); end
    n_cmp++; if (uf_b !== 1'b0) begin n_fail++; $display("FAIL reg0_no_underflow got %b want 0", uf_b); end
  endtask

  task automatic test_conflict();
    issue_valid = 1'b1; issue_tag = 5'd7;
    tick(); tick(); idle();
    set_rd(0, 7);
    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
    #1;
    n_cmp++; if (rd_pending_b[0] !== 1'b1) begin n_fail++; $display("FAIL conflict_pending_before got %b want 1", rd_pending_b[0]); end
    n_cmp++; if (rd_value_b[31:0] !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass_winner got %h want 22", rd_value_b[31:0]); end
    tick(); idle();
    #1;
    n_cmp++; if (rd_value_n[31:0] !== 32'h22) begin n_fail++; $display("FAIL conflict_winner got %h want 22", rd_value_n[31:0]); end
    n_cmp++; if (rd_pending_n[0] !== 1'b0) begin n_fail++; $display("FAIL conflict_count_zero got %b want 0", rd_pending_n[0]); end
    n_cmp++; if (uf_b !== 1'b0) begin n_fail++; $display("FAIL conflict_no_underflow got %b want 0", uf_b); end
  endtask

  task automatic test_saturate();
    issue_valid = 1'b1; issue_tag = 5'd4;
    tick(); tick(); tick();
    n_cmp++; if (issue_ready_b !== 1'b0) begin n_fail++; $display("FAIL sat_ready_low got %b want 0", issue_ready_b); end
    tick(); idle();
    set_wr(0, 4, 32'hA4);
    tick(); idle();
    issue_tag = 5'd4;
    #1;
    n_cmp++; if (issue_ready_b !== 1'b1) begin n_fail++; $display("FAIL sat_ready_after_wb got %b want 1", issue_ready_b); end
    issue_valid = 1'b1;
    tick(); idle();
    issue_tag = 5'd4;
    #1;
    n_cmp++; if (issue_ready_n !== 1'b0) begin n_fail++; $display("FAIL sat_refill got %b want 0", issue_ready_n); end
    set_wr(0, 4, 32'hB4); set_wr(1, 4, 32'hC4);
    tick(); idle();
    set_wr(0, 4, 32'hD4);
    tick(); idle();
    set_rd(0, 4);
    #1;
    n_cmp++; if (rd_pending_b[0] !== 1'b0) begin n_fail++; $display("FAIL sat_drained got %b want 0", rd_pending_b[0]); end
    n_cmp++; if (uf_b !== 1'b0) begin n_fail++; $display("FAIL sat_fourth_dropped got %b want 0", uf_b); end
  endtask

  task automatic test_issue_wb_same();
    issue_valid = 1'b1; issue_tag = 5'd9;
    tick();
    set_wr(0, 9, 32'h99);
    tick(); idle();
    set_rd(1, 9);
    #1;
    n_cmp++; if (rd_pending_b[1] !== 1'b1) begin n_fail++; $display("FAIL issue_wb_net_zero got %b want 1", rd_pending_b[1]); end
    set_wr(1, 9, 32'h9A);
    tick(); idle();
    #1;
    n_cmp++; if (rd_pending_b[1] !== 1'b0 || uf_b !== 1'b0) begin n_fail++; $display("FAIL issue_wb_count_one got %b/%b want 0/0", rd_pending_b[1], uf_b); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 7));
      wr_en = '0;
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 2) == 0) set_wr(p, $urandom_range(0, 7), $urandom);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_tag = TW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_cmp++; if (rd_value_b[p*W +: W] !== exp_read(int'(rd_tag[p*TW +: TW]), 1'b1)) begin n_fail++; $display("FAIL rand_read_byp cyc %0d port %0d got %h want %h", c, p, rd_value_b[p*W +: W], exp_read(int'(rd_tag[p*TW +: TW]), 1'b1)); end
        n_cmp++; if (rd_value_n[p*W +: W] !== exp_read(int'(rd_tag[p*TW +: TW]), 1'b0)) begin n_fail++; $display("FAIL rand_read_nobyp cyc %0d port %0d got %h want %h", c, p, rd_value_n[p*W +: W], exp_read(int'(rd_tag[p*TW +: TW]), 1'b0)); end
        n_cmp++; if (rd_pending_b[p] !== (m_cnt[rd_tag[p*TW +: TW]] != 0)) begin n_fail++; $display("FAIL rand_pending cyc %0d port %0d got %b want %0d", c, p, rd_pending_b[p], m_cnt[rd_tag[p*TW +: TW]] != 0); end
      end
      n_cmp++; if (issue_ready_b !== exp_ready()) begin n_fail++; $display("FAIL rand_issue_ready cyc %0d got %b want %b", c, issue_ready_b, exp_ready()); end
      n_cmp++; if (uf_b !== m_uf || uf_n !== m_uf) begin n_fail++; $display("FAIL rand_underflow cyc %0d got %b%b want %b", c, uf_b, uf_n, m_uf); end
      model_edge();
      @(posedge clock);
      #1;
    end
    idle();
  endtask

  task automatic test_flush();
    reset_n = 1'b0; #1; reset_n = 1'b1; model_reset();
    issue_valid = 1'b1; issue_tag = 5'd5; tick(); tick();
    issue_tag = 5'd6; tick(); idle();
    flush = 1'b1; set_wr(0, 10, 32'hABCD);
    tick(); idle();
    for (int r = 0; r < NR; r++) begin
      set_rd(0, r);
      #1;
      n_cmp++; if (rd_pending_b[0] !== 1'b0) begin n_fail++; $display("FAIL flush_pending reg %0d got %b want 0", r, rd_pending_b[0]); end
    end
    set_rd(1, 10);
    #1;
    n_cmp++; if (rd_value_n[63:32] !== 32'hABCD) begin n_fail++; $display("FAIL flush_write_commits got %h want abcd", rd_value_n[63:32]); end
    n_cmp++; if (uf_b !== 1'b0) begin n_fail++; $display("FAIL flush_no_underflow got %b want 0", uf_b); end
  endtask

  task automatic test_underflow();
    set_wr(0, 12, 32'hC12);
    #1;
    n_cmp++; if (uf_b !== 1'b0) begin n_fail++; $display("FAIL uf_before_edge got %b want 0", uf_b); end
    tick(); idle();
    n_cmp++; if (uf_b !== 1'b1) begin n_fail++; $display("FAIL uf_rises got %b want 1", uf_b); end
    tick(); tick();
    n_cmp++; if (uf_n !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %b want 1", uf_n); end
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_tag = 5'd2;
    tick(); idle();
    set_rd(0, 10); set_rd(1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (uf_b !== 1'b0 || uf_n !== 1'b0) begin n_fail++; $display("FAIL async_reset_uf got %b%b want 00", uf_b, uf_n); end
    n_cmp++; if (rd_value_n[31:0] !== 32'h0) begin n_fail++; $display("FAIL async_reset_data got %h want 0", rd_value_n[31:0]); end
    n_cmp++; if (rd_pending_b[1] !== 1'b0) begin n_fail++; $display("FAIL async_reset_pending got %b want 0", rd_pending_b[1]); end
    @(posedge clock); #1;
    reset_n = 1'b1; model_reset();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_saturate();
    test_issue_wb_same();
    test_random();
    test_flush();
    test_underflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboarded.md
Name: regfile_scoreboarded

Overview:
- Parametrised successor to the pipeline's integer register file.
- Adds configurable width, depth and port counts, plus asynchronous reset and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard so the 7-stage pipeline's issue stage can detect RAW hazards on in-flight results.
- Sits between decode/issue (reads, marks destinations) and writeback (commits results).

Parameters:
- WORD_SIZE, 32, data width of each register
- NUM_REGS, 32, register count including hardwired-zero register 0; power of two, >= 2
- TAG_W, $clog2(NUM_REGS), register index width (derived, not overridden)
- NUM_READ, 2, number of read ports
- NUM_WRITE, 2, number of writeback ports
- PEND_W, 2, width of each pending counter; saturation value PMAX = 2^PEND_W - 1
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the registered value only

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rd_tag  in  NUM_READ*TAG_W  read indices; port i occupies bits [i*TAG_W +: TAG_W]
- rd_value  out  NUM_READ*WORD_SIZE  read data, same packing
- rd_pending  out  NUM_READ  port i's register has pending count != 0
- wr_en  in  NUM_WRITE  write enable per writeback port
- wr_tag  in  NUM_WRITE*TAG_W  write indices
- wr_value  in  NUM_WRITE*WORD_SIZE  write data
- issue_valid  in  1  mark issue_tag as having one more in-flight producer
- issue_tag  in  TAG_W  destination being issued
- issue_ready  out  1  issue_tag's counter below PMAX, or issue_tag == 0
- flush  in  1  synchronous clear of all pending counters (data untouched)
- underflow_err  out  1  sticky: a write hit a register whose counter was 0

Behaviour:
- Reset (reset_n low, asynchronous): all registers 0, all counters 0, underflow_err 0. rd_value reflects zeroed contents immediately.
- Register 0: always reads 0; writes ignored; counter fixed at 0; rd_pending 0; issue to 0 accepted (issue_ready 1) with no effect.
- Writes commit on the rising edge when wr_en[j] is set and wr_tag[j] != 0.
- Write conflict: if two ports target the same register in one cycle, the highest port index wins the data.
- Read (combinational): rd_value[i] = stored value of rd_tag[i].
  - BYPASS=1: if any enabled write targets rd_tag[i] (nonzero), rd_value[i] is instead the winning write's wr_value.
  - rd_pending[i] is always computed from the registered counter; no bypass.
- Counter update per register r != 0, each edge:
  - inc = issue_valid && issue_ready && issue_tag == r
  - dec = number of enabled write ports whose wr_tag == r
  - next = count + inc - dec, clamped at 0
  - If count + inc < dec: counter becomes 0 and underflow_err sets; it stays set until reset.
  - Simultaneous issue and writeback to the same register: net change is 0 for one write.
- issue_ready is combinational from the current counter of issue_tag. An issue with issue_ready low is dropped with no state change; the issue stage must stall.
- flush: all counters go to 0 at the edge; takes priority over same-cycle inc/dec. Writes in that cycle still commit data. No underflow is flagged in a flush cycle.
- Latency: a write is visible through the array the cycle after it commits, or the same cycle with BYPASS=1. A counter change is visible on rd_pending/issue_ready the next cycle.
- Reset asserted mid-operation: all state clears immediately; in-flight writes on that edge are lost.

Test Plan:
- Reset, then read regs 0, 5 and 31 -> all read 0x00000000 with rd_pending 0.
- Write reg 3 = 0xDEADBEEF on port 0 while reading reg 3 in the same cycle:
  - BYPASS=1 -> 0xDEADBEEF that cycle.
  - BYPASS=0 -> 0 that cycle, then 0xDEADBEEF the next cycle.
  - Writing 0x1234 to reg 0 -> reg 0 still reads 0.
- Ports 0 and 1 both write reg 7 (0x11 and 0x22) in one cycle:
  - reg 7 = 0x22.
  - With reg 7's counter previously at 2 -> counter becomes 0, no underflow_err.
- Issue to reg 4 three times with PEND_W=2 -> counter 3, issue_ready low. A fourth issue is dropped. One writeback -> counter 2, issue_ready high.
- Issue and writeback to reg 9 in the same cycle with counter at 1 -> counter remains 1, rd_pending stays 1.
- Write reg 12 with counter 0 -> underflow_err rises and stays high.
  - flush with counters nonzero -> all rd_pending 0 the next cycle.
  - Assert reset_n low mid-cycle -> underflow_err and all data clear without waiting for a clock edge.
